// File: rtl/md_unit_pkg.sv
// ---------------------------------------------------------------------------
// md_unit_pkg
//   Shared definitions for the execute-stage multiply/divide unit.
//   - md_op_e      : MDUOp codes, shared with the E-stage controller
//   - MULT/DIV_CYCLES_DEF : default busy latencies
//   - is_start_op  : true for the op codes that launch a multi-cycle operation
// ---------------------------------------------------------------------------
package md_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// ---------------------------------------------------------------------------
// md_unit_if
//   E-stage <-> MDU bus.
//   Request : en, op[3:0], A[31:0], B[31:0]       (controller -> MDU)
//   Status  : start, busy                          (MDU -> hazard unit)
//   Data    : HI[31:0], LO[31:0], out[31:0]        (MDU -> pipeline)
//   master = E-stage side, slave = the MDU itself.
// ---------------------------------------------------------------------------
interface md_unit_if;

  logic        en;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] out;

  modport master (
    output en, op, A, B,
    input  start, busy, HI, LO, out
  );

  modport slave (
    input  en, op, A, B,
    output start, busy, HI, LO, out
  );

endinterface

// File: rtl/md_arith.sv
// ---------------------------------------------------------------------------
// md_arith
//   Purely combinational arithmetic core of the MDU.
//   a, b   : operands (rs, rt)
//   op     : MDUOp; selects mult/multu/div/divu
//   hi, lo : result; {hi,lo} is the 64-bit product, or hi=remainder,
//            lo=quotient for divides
//   div0   : divide op with b==0 (result must not be committed)
// ---------------------------------------------------------------------------
module md_arith
  import md_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider serves both divides: signed operands are reduced to
  // magnitudes and the signs are re-applied afterwards. This also keeps
  // 0x80000000 / -1 well defined (magnitude 2^31 negates back to 0x80000000).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps synthesis from inferring a latch.
    signed_div = (op == OP_DIV);
    dvd        = a;
    dvs        = b;
    if (signed_div) begin
      dvd = a[31] ? (~a + 32'd1) : a;
      dvs = b[31] ? (~b + 32'd1) : b;
    end
    // Divisor forced non-zero so the divider never sees /0; the result is
    // discarded via div0 anyway.
    if (b == 32'd0) begin
      dvs = 32'd1;
    end
    quo_mag = dvd / dvs;
    rem_mag = dvd % dvs;
    quo     = quo_mag;
    rem     = rem_mag;
    if (signed_div) begin
      if (a[31] ^ b[31]) quo = ~quo_mag + 32'd1;
      if (a[31])         rem = ~rem_mag + 32'd1;
    end
  end

  always_comb begin
    hi   = 32'd0;
    lo   = 32'd0;
    div0 = 1'b0;
    unique case (op)
      OP_MULT:  {hi, lo} = prod_s;
      OP_MULTU: {hi, lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        hi   = rem;
        lo   = quo;
        div0 = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
//   Execute-stage multiply/divide unit. Owns architectural HI/LO, models the
//   multi-cycle latency of mult/div with a down-counter and returns mfhi/mflo
//   data on bus.out.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears HI/LO, counter and pending result
//   bus   : md_unit_if.slave (en/op/A/B in; start/busy/HI/LO/out out)
//   The result is computed in the accept cycle and parked in pend_hi/pend_lo;
//   it lands in HI/LO on the edge where the counter goes 1 -> 0.
// ---------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi_q,       hi_d;
  logic [31:0]      lo_q,       lo_d;
  logic [31:0]      pend_hi_q,  pend_hi_d;
  logic [31:0]      pend_lo_q,  pend_lo_d;
  logic             pend_div0_q, pend_div0_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        arith_div0;
  logic        busy;
  logic        start;

  md_arith u_arith (
    .a    (bus.A),
    .b    (bus.B),
    .op   (bus.op),
    .hi   (arith_hi),
    .lo   (arith_lo),
    .div0 (arith_div0)
  );

  assign busy  = (cnt_q != '0);
  assign start = bus.en && is_start_op(bus.op) && !busy;

  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_div0_d = pend_div0_q;
    cnt_d       = cnt_q;

    if (start) begin
      pend_hi_d   = arith_hi;
      pend_lo_d   = arith_lo;
      pend_div0_d = arith_div0;
      cnt_d       = is_div_op(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      // Last busy cycle: commit, unless the op was a divide by zero.
      if (cnt_q == CNT_W'(1) && !pend_div0_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end

    // Moves to HI/LO only when idle; while busy every request is dropped.
    if (bus.en && !busy) begin
      if (bus.op == OP_MTHI) hi_d = bus.A;
      if (bus.op == OP_MTLO) lo_d = bus.A;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset) begin
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_div0_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_div0_q <= pend_div0_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.start = start;
  assign bus.busy  = busy;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

  always_comb begin
    bus.out = 32'd0;
    if (bus.op == OP_MFHI)      bus.out = hi_q;
    else if (bus.op == OP_MFLO) bus.out = lo_q;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit of the P6 pipeline.
- Consumes enMDU/MDUOp and the forwarded rs/rt operands produced by the E-stage controller.
- Holds the architectural HI/LO registers, models multi-cycle mult/div latency with start/busy, and returns mfhi/mflo data on the MD write-back path.
- The hazard unit uses start|busy to stall any MDU-class instruction in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; clears all state when 0 at a rising edge
- en  in  1  enMDU from E controller; qualifies op for state-changing ops
- op  in  4  MDUOp from E controller
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- start  out  1  combinational: en & op∈{MULT,MULTU,DIV,DIVU} & ~busy
- busy  out  1  registered: operation in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register
- out  out  32  combinational: op==MFHI ? HI : op==MFLO ? LO : 0 (en not required)

Behaviour:
- Reset (reset==0 at edge): HI=0, LO=0, busy=0, counter=0, pending regs=0. Any in-flight operation is abandoned, so HI/LO are not written. start and out follow from the cleared state.
- Accept rule: when start==1 at an edge:
  - compute the result from A/B that cycle and latch it into pend_hi/pend_lo;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - busy=1 from the next cycle.
- MULT: {pend_hi,pend_lo} = $signed(A)*$signed(B), 64-bit. MULTU: unsigned 64-bit product.
- DIV: pend_lo = signed quotient truncated toward zero; pend_hi = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, DIV or DIVU): timing is unchanged (busy for DIV_CYCLES), but HI/LO keep their old values at commit.
- Counter: decrements each edge while nonzero. busy = (counter!=0).
- Commit: on the edge where the counter goes 1→0, HI<=pend_hi and LO<=pend_lo.
- Timing: start is high in cycle T, busy is high for cycles T+1..T+N, and new HI/LO are visible from T+N+1.
- MTHI/MTLO: when en & op==MTHI (MTLO) & ~busy, HI (LO) <= A at the edge, visible next cycle.
- Requests while busy: any en request is ignored (no start, no mt write). The hazard unit guarantees none arrive; the bench checks state is unchanged.
- MFHI/MFLO: out reflects current HI/LO combinationally. During busy it shows the old values; the stall logic prevents that read from being used.
- op==0 or an undefined code: no state change, out=0.
- Simultaneous commit and new request: a request in the commit cycle is still busy=1 and is ignored. The next start is possible in cycle T+N+1.

Decomposition:
- const.v (shared) holds the MDUOp codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. The E controller uses the same codes.
- One combinational sub-module, md_arith (A, B, op → 64-bit {hi,lo}, div0 flag), isolates the arithmetic. md_unit keeps the counter, pending registers and HI/LO.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3 → start=1 one cycle; busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; out with op=MFLO = 0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=-7 (0xFFFFFFF9), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=0 with prior HI=0x11, LO=0x22 → busy 10 cycles; HI/LO remain 0x11/0x22.
- mtlo A=0x1234 → LO=0x1234 next cycle. Then start mult 2*3 and issue mthi A=0x55 at busy cycle 2 → mthi ignored; final HI=0, LO=6.
- Start div 100/7, drive reset=0 at busy cycle 4 → next cycle busy=0, HI=LO=0, and no later commit occurs.
